// File: rtl/fifo_nibble_packer.sv
// Purpose: pops NIB_W-bit nibbles from a show-ahead FIFO and packs NIBS of them into one OUT_W word.
// Latency: final-nibble pop in cycle N gives m_valid in cycle N+1 when the output queue is empty.
// Backpressure: 2-entry output queue; pops stall on the final nibble while the queue is full.
module fifo_nibble_packer #(
    parameter int NIB_W     = 4,
    parameter int NIBS      = 2,
    parameter int LSB_FIRST = 1
) (
    input  logic                  clk,
    input  logic                  rstN,
    input  logic                  fifo_empty,
    input  logic [NIB_W-1:0]      fifo_read_data,
    output logic                  fifo_read_en,
    input  logic                  flush,
    output logic                  m_valid,
    output logic [NIB_W*NIBS-1:0] m_data,
    input  logic                  m_ready,
    output logic [7:0]            word_cnt,
    output logic                  drop_partial
);

    localparam int OUT_W = NIB_W * NIBS;
    localparam int IDX_W = (NIBS > 1) ? $clog2(NIBS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBS - 1);

    logic [IDX_W-1:0] nib_idx_q, nib_idx_d;
    logic [OUT_W-1:0] asm_q, asm_d;
    logic [OUT_W-1:0] word_full;
    logic [OUT_W-1:0] q_mem_q [2];
    logic             wr_ptr_q, rd_ptr_q;
    logic [1:0]       out_cnt_q, out_cnt_d;
    logic [7:0]       word_cnt_q;
    logic             drop_q;

    logic last_nib;
    logic pop;
    logic push;
    logic hs;

    assign last_nib = (nib_idx_q == LAST_IDX);

    // Pop only from registered state, the empty flag and flush; m_ready never reaches this path.
    assign fifo_read_en = rstN && !fifo_empty && !flush && (!last_nib || (out_cnt_q != 2'd2));

    assign pop  = fifo_read_en;
    assign push = pop && last_nib;
    assign hs   = m_valid && m_ready;

    assign m_valid      = (out_cnt_q != 2'd0);
    assign m_data       = q_mem_q[rd_ptr_q];
    assign word_cnt     = word_cnt_q;
    assign drop_partial = drop_q;

    // Assembly register with the incoming nibble dropped into slot nib_idx.
    always_comb begin
        word_full = asm_q;
        for (int i = 0; i < NIBS; i++) begin
            if (nib_idx_q == IDX_W'(i)) begin
                if (LSB_FIRST != 0) begin
                    word_full[i*NIB_W +: NIB_W] = fifo_read_data;
                end else begin
                    word_full[(NIBS-1-i)*NIB_W +: NIB_W] = fifo_read_data;
                end
            end
        end
    end

    // Nibble index and assembly next state; flush wins and suppresses the pop.
    always_comb begin
        nib_idx_d = nib_idx_q;
        asm_d     = asm_q;
        if (flush) begin
            nib_idx_d = '0;
        end else if (pop) begin
            asm_d     = word_full;
            nib_idx_d = last_nib ? '0 : nib_idx_q + IDX_W'(1);
        end
    end

    // Output queue occupancy: simultaneous push and pop leave it unchanged.
    always_comb begin
        out_cnt_d = out_cnt_q;
        case ({push, hs})
            2'b10:   out_cnt_d = out_cnt_q + 2'd1;
            2'b01:   out_cnt_d = out_cnt_q - 2'd1;
            default: out_cnt_d = out_cnt_q;
        endcase
    end

    // Packing state registers.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            nib_idx_q <= '0;
            asm_q     <= '0;
            drop_q    <= 1'b0;
        end else begin
            nib_idx_q <= nib_idx_d;
            asm_q     <= asm_d;
            drop_q    <= flush && (nib_idx_q != '0);
        end
    end

    // Output queue storage, pointers, occupancy and accepted-word counter.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            q_mem_q[0] <= '0;
            q_mem_q[1] <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            out_cnt_q  <= 2'd0;
            word_cnt_q <= 8'd0;
        end else begin
            if (push) begin
                q_mem_q[wr_ptr_q] <= word_full;
                wr_ptr_q          <= ~wr_ptr_q;
            end
            if (hs) begin
                rd_ptr_q   <= ~rd_ptr_q;
                word_cnt_q <= word_cnt_q + 8'd1;
            end
            out_cnt_q <= out_cnt_d;
        end
    end

endmodule

// File: doc/fifo_nibble_packer.md
Name: fifo_nibble_packer

Overview:
Downstream consumer of the 4-bit FIFO. It pops nibbles from the FIFO read port and packs NIBS consecutive nibbles into one output word. Packed words go out on a valid/ready stream through a 2-entry output queue. It is the FIFO's only reader, so it owns fifo_read_en and must never read when the FIFO is empty.

Parameters:
NIB_W, 4, width of one FIFO entry; must equal the FIFO write_data/read_data width.
NIBS, 2, nibbles per output word; legal range 2..8.
LSB_FIRST, 1, 1: first popped nibble lands in m_data[NIB_W-1:0]; 0: first nibble lands in the MSB nibble.
(derived) OUT_W = NIB_W*NIBS.

Ports:
clk  in  1  rising-edge clock.
rstN  in  1  asynchronous active-low reset.
fifo_empty  in  1  FIFO empty flag.
fifo_read_data  in  NIB_W  FIFO head data; valid in the same cycle fifo_read_en is high and fifo_empty is low (show-ahead).
fifo_read_en  out  1  pop request to the FIFO.
flush  in  1  synchronous single-cycle request to discard a partially assembled word.
m_valid  out  1  output word valid.
m_data  out  OUT_W  packed output word.
m_ready  in  1  sink ready.
word_cnt  out  8  count of words accepted by the sink; wraps 255->0.
drop_partial  out  1  one-cycle pulse; a partial word was discarded by flush.

Behaviour:
- Reset (rstN low, asynchronous): every output is 0, including fifo_read_en, m_valid, m_data, word_cnt and drop_partial. Internal state also clears: nib_idx=0, assembly register=0, queue count=0, queue pointers=0.
- State: nib_idx counts 0..NIBS-1. out_cnt counts 0..2 and is the occupancy of the output queue.
- fifo_read_en = !fifo_empty && !flush && (nib_idx != NIBS-1 || out_cnt < 2).
  - fifo_read_en is a combinational function of registered state plus fifo_empty and flush only.
  - There is no combinational path from m_ready to fifo_read_en.
- Pop with nib_idx < NIBS-1:
  - fifo_read_data is stored in nibble slot nib_idx of the assembly register (slot 0 = LSB when LSB_FIRST=1, slot 0 = MSB when LSB_FIRST=0).
  - nib_idx increments.
- Pop with nib_idx == NIBS-1:
  - The completed word (assembly register plus the current nibble) is written into the output queue.
  - nib_idx returns to 0.
  - The assembly register is not cleared; stale slots are always overwritten before reuse.
- Latency: final-nibble pop in cycle N, with the queue empty, gives m_valid=1 in cycle N+1.
- Output queue:
  - 2-entry, in order; m_valid = (out_cnt != 0); m_data = head entry.
  - A handshake (m_valid && m_ready) pops the head.
  - A push and a pop in the same cycle leave out_cnt unchanged; this is legal at out_cnt=1 and at out_cnt=2. At out_cnt=2 the push is blocked by the fifo_read_en rule, so this case reduces to pop only.
  - m_data is stable while m_valid && !m_ready.
  - Sustained throughput is one word per NIBS cycles when the FIFO never runs empty and m_ready=1.
- word_cnt increments by 1 on each handshake, modulo 256.
- flush:
  - In a flush cycle there is no pop.
  - nib_idx resets to 0 at the next edge.
  - drop_partial=1 in the next cycle if and only if nib_idx != 0 in the flush cycle.
  - The output queue and word_cnt are unaffected.
  - Consecutive flush cycles give at most one drop_partial pulse per discarded partial word.
- Empty FIFO: fifo_read_en=0, state holds, partial assembly is retained indefinitely.
- Reset mid-operation: any partial word and any queued words are lost; no drop_partial pulse is produced.
- Invariants for the bench:
  - Never fifo_read_en && fifo_empty.
  - Never a queue push when out_cnt==2.
  - out_cnt <= 2 at all times.

Test Plan:
1. Stream in order: FIFO holds 1,2,3,4, m_ready=1, LSB_FIRST=1, NIBS=2 -> m_data 0x21 then 0x43, each m_valid one cycle; word_cnt ends at 2; 4 pops total.
2. MSB order: same stimulus with LSB_FIRST=0 -> m_data 0x12 then 0x34.
3. Backpressure: m_ready=0, FIFO holds 0..7 -> 2 words queued (0x10, 0x32); nibble 4 popped, then fifo_read_en=0 with nib_idx=1; m_data stays 0x10; release m_ready -> 0x10, 0x32, 0x54, 0x76 delivered in order.
4. Flush of a partial word: pop 0xA, pulse flush -> drop_partial=1 next cycle; then pop 5,6 -> m_data 0x65 (0xA is not present); flush with nib_idx=0 -> no drop_partial pulse.
5. Underflow guard: FIFO empty with one nibble held -> fifo_read_en stays 0 for 20 cycles; m_valid=0; then one more nibble is written -> word completes one cycle after the pop.
6. Async reset with out_cnt=2 and nib_idx=1: assert rstN=0 mid-cycle -> m_valid, fifo_read_en, word_cnt and drop_partial are 0 immediately; after release the first word is built from fresh pops only.
